// File: rtl/uart_rx_os16.sv
// 8N1-style UART receiver on a 16x oversampling strobe. It takes a three-sample majority vote per bit
// and presents each received word on a one-entry valid/ready buffer.
module uart_rx_os16 #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   rxs;
  logic [2:0]             state;
  logic [3:0]             cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   smp_7;
  logic                   smp_8;
  logic                   bit_val;
  logic                   maj;
  logic                   sampling;

  // synchroniser stage boundary: the line idles high, so the flops reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= '1;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx};
  end

  assign rxs      = sync_p0[SYNC_STAGES-1];
  assign maj      = majority3(smp_7, smp_8, rxs);
  assign sampling = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign busy     = (state != S_IDLE);

  // frame FSM stage boundary: moves on enable_16 ticks, while the output handshake runs every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      bit_idx   <= '0;
      shreg     <= '0;
      smp_7     <= 1'b1;
      smp_8     <= 1'b1;
      bit_val   <= 1'b1;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;

      if (enable_16) begin
        if (sampling) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) smp_7 <= rxs;
          if (cnt == 4'd8) smp_8 <= rxs;
          if (cnt == 4'd9) bit_val <= maj;
        end

        case (state)
          S_IDLE: begin
            cnt <= 4'd0;
            if (!rxs) state <= S_START;
          end
          S_START: begin
            if (cnt == 4'd9 && maj) begin
              state <= S_IDLE;
              cnt   <= 4'd0;
            end else if (cnt == 4'd15) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
          S_DATA: begin
            if (cnt == 4'd15) begin
              shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + IDX_W'(1);
              if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= S_STOP;
            end
          end
          S_STOP: begin
            // Deciding at mid stop bit leaves half a bit to catch the next start edge
            if (cnt == 4'd9) begin
              cnt <= 4'd0;
              if (maj) begin
                state <= S_IDLE;
                if (!valid || ready) begin
                  data  <= shreg;
                  valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                state     <= S_BREAK;
                frame_err <= 1'b1;
              end
            end
          end
          S_BREAK: begin
            if (rxs) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: a tick every 4 clks, so one bit lasts 64 clks.
// Each scenario task checks its own expected values.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_16;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [1:0] div = 2'd0;

  int n_vrise = 0, n_vhigh = 0, n_fe = 0, n_ov = 0, n_viol = 0;
  logic [7:0] rise_data = 8'h00;
  int rise_cyc = 0;
  logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

  uart_rx_os16 #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable_16(enable_16), .rx(rx),
    .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div <= div + 2'd1;
    cyc <= cyc + 1;
  end
  assign enable_16 = (div == 2'd3);

  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      n_vrise++;
      rise_data = data;
      rise_cyc = cyc;
    end
    if (valid) n_vhigh++;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (frame_err && overrun) n_viol++;
    if (frame_err && prev_fe) n_viol++;
    if (overrun && prev_ov) n_viol++;
    prev_valid = valid;
    prev_fe = frame_err;
    prev_ov = overrun;
  end

  task automatic align_tick();
    @(negedge clk);
    while (div != 2'd3) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input logic glitch);
    for (int c = 0; c < 64; c++) begin
      rx = (glitch && c >= 38 && c <= 41) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch,
                            output int start_cyc);
    align_tick();
    start_cyc = cyc;
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    drive_bit(stop, glitch);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {frame_err, overrun}); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if ({valid, busy} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b want=00", {valid, busy}); end
  endtask

  task automatic test_basic();
    int s, vr, vh, fe, ov;
    vr = n_vrise; vh = n_vhigh; fe = n_fe; ov = n_ov;
    ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0, s);
    repeat (8) @(negedge clk);
    total++; if (n_vrise - vr !== 1) begin bad++; $display("FAIL basic_valid_count got=%0d want=1", n_vrise - vr); end
    total++; if (n_vhigh - vh !== 1) begin bad++; $display("FAIL basic_valid_width got=%0d want=1", n_vhigh - vh); end
    total++; if (rise_data !== 8'h55) begin bad++; $display("FAIL basic_data got=%h want=55", rise_data); end
    total++; if (rise_cyc - s !== 621) begin bad++; $display("FAIL basic_latency got=%0d want=621", rise_cyc - s); end
    total++; if (n_fe - fe !== 0 || n_ov - ov !== 0) begin bad++; $display("FAIL basic_errs got fe=%0d ov=%0d want 0 0", n_fe - fe, n_ov - ov); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
  endtask

  task automatic test_false_start();
    int vr, fe;
    logic b_mid;
    vr = n_vrise; fe = n_fe;
    align_tick();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    b_mid = busy;
    repeat (26) @(negedge clk);
    total++; if (b_mid !== 1'b1) begin bad++; $display("FAIL false_start_busy_mid got=%b want=1", b_mid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_busy_end got=%b want=0", busy); end
    repeat (700) @(negedge clk);
    total++; if (n_vrise - vr !== 0 || n_fe - fe !== 0) begin bad++; $display("FAIL false_start_outputs got vr=%0d fe=%0d want 0 0", n_vrise - vr, n_fe - fe); end
  endtask

  task automatic test_break();
    int s, vr, fe;
    vr = n_vrise; fe = n_fe;
    send_frame(8'hA5, 1'b0, 1'b0, s);
    rx = 1'b0;
    repeat (20 * 64) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_held got=%b want=1", busy); end
    rx = 1'b1;
    repeat (128) @(negedge clk);
    total++; if (n_fe - fe !== 1) begin bad++; $display("FAIL break_fe_count got=%0d want=1", n_fe - fe); end
    total++; if (n_vrise - vr !== 0) begin bad++; $display("FAIL break_no_valid got=%0d want=0", n_vrise - vr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_busy_end got=%b want=0", busy); end
    send_frame(8'h3C, 1'b1, 1'b0, s);
    repeat (8) @(negedge clk);
    total++; if (n_vrise - vr !== 1 || rise_data !== 8'h3C) begin bad++; $display("FAIL break_recover got n=%0d data=%h want 1 3c", n_vrise - vr, rise_data); end
    total++; if (n_fe - fe !== 1) begin bad++; $display("FAIL break_fe_after got=%0d want=1", n_fe - fe); end
  endtask

  task automatic test_overrun();
    int s, ov;
    ov = n_ov;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, s);
    repeat (8) @(negedge clk);
    total++; if (valid !== 1'b1 || data !== 8'h11) begin bad++; $display("FAIL ovr_first got v=%b d=%h want 1 11", valid, data); end
    send_frame(8'h22, 1'b1, 1'b0, s);
    repeat (8) @(negedge clk);
    total++; if (n_ov - ov !== 1) begin bad++; $display("FAIL ovr_pulse_count got=%0d want=1", n_ov - ov); end
    total++; if (valid !== 1'b1 || data !== 8'h11) begin bad++; $display("FAIL ovr_hold got v=%b d=%h want 1 11", valid, data); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", valid); end
    total++; if (data !== 8'h11) begin bad++; $display("FAIL ovr_data_kept got=%h want=11", data); end
    ready = 1'b1;
  endtask

  task automatic test_majority();
    int s, vr, fe;
    vr = n_vrise; fe = n_fe;
    send_frame(8'hC3, 1'b1, 1'b1, s);
    repeat (8) @(negedge clk);
    total++; if (n_vrise - vr !== 1 || rise_data !== 8'hC3) begin bad++; $display("FAIL majority_data got n=%0d data=%h want 1 c3", n_vrise - vr, rise_data); end
    total++; if (n_fe - fe !== 0) begin bad++; $display("FAIL majority_fe got=%0d want=0", n_fe - fe); end
  endtask

  task automatic test_reset_midframe();
    int s, vr, fe;
    logic [7:0] d;
    d = 8'hFF;
    align_tick();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({valid, busy, frame_err, overrun} !== 4'b0000 || data !== 8'h00) begin bad++; $display("FAIL mid_reset_outputs got v=%b b=%b fe=%b ov=%b d=%h want all 0", valid, busy, frame_err, overrun, data); end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    vr = n_vrise; fe = n_fe;
    repeat (640) @(negedge clk);
    total++; if (n_vrise - vr !== 0 || n_fe - fe !== 0) begin bad++; $display("FAIL mid_no_partial got vr=%0d fe=%0d want 0 0", n_vrise - vr, n_fe - fe); end
    send_frame(8'h7E, 1'b1, 1'b0, s);
    repeat (8) @(negedge clk);
    total++; if (n_vrise - vr !== 1 || rise_data !== 8'h7E) begin bad++; $display("FAIL mid_after_data got n=%0d data=%h want 1 7e", n_vrise - vr, rise_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_break();
    test_overrun();
    test_majority();
    test_reset_midframe();
    total++; if (n_viol !== 0) begin bad++; $display("FAIL pulse_rules got=%0d want=0", n_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
